// File: rtl/qam_pkg.sv
// Shared types and helpers for the rectangular-pulse QAM demodulator.
package qam_pkg;

   localparam int SAMPLE_W = 16;
   localparam int BITS_W   = 6;

   typedef enum logic [1:0] {
      SYB_BPSK  = 2'd0,
      SYB_QPSK  = 2'd1,
      SYB_16QAM = 2'd2,
      SYB_64QAM = 2'd3
   } syb_e;

   typedef enum logic {
      SER_IDLE  = 1'b0,
      SER_SHIFT = 1'b1
   } ser_state_e;

   // Decision bits carried on each axis.
   function automatic logic [2:0] bits_per_axis(input syb_e syb);
      case (syb)
         SYB_16QAM: return 3'd2;
         SYB_64QAM: return 3'd3;
         default:   return 3'd1;
      endcase
   endfunction

   // Total hard bits per symbol (BPSK uses the I axis only).
   function automatic logic [2:0] bits_per_sym(input syb_e syb);
      case (syb)
         SYB_BPSK:  return 3'd1;
         SYB_QPSK:  return 3'd2;
         SYB_16QAM: return 3'd4;
         default:   return 3'd6;
      endcase
   endfunction

   // Clamp a wide signed value into the 16-bit signed range.
   function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
      if (v > 32'sd32767)
         return 16'sh7fff;
      else if (v < -32'sd32768)
         return 16'sh8000;
      else
         return v[15:0];
   endfunction

endpackage

// File: rtl/qam_slicer.sv
// Single-axis hard decision: maps a Q1.15 soft value onto one of 2**n
// offset-binary levels, clamping anything beyond the outer points.
module qam_slicer
   import qam_pkg::*;
(
   input  logic signed [15:0] v,
   input  logic        [2:0]  n,
   output logic        [2:0]  idx
);

   logic signed [17:0] v_ext;
   logic signed [17:0] shifted;
   logic signed [17:0] biased;
   logic signed [17:0] top;

   assign v_ext = {{2{v[15]}}, v};

   // Scale to the level grid, re-centre, then clamp to [0, 2**n-1].
   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred.
      idx     = '0;
      shifted = v_ext >>> (4'd15 - {1'b0, n});
      biased  = shifted + $signed(18'd1 << (n - 3'd1));
      top     = $signed((18'd1 << n) - 18'd1);
      if (biased < 18'sd0)
         idx = '0;
      else if (biased > top)
         idx = top[2:0];
      else
         idx = biased[2:0];
   end

endmodule

// File: rtl/qam_rect_demod.sv
// Coherent IQ integrate-and-dump receiver for rect-shaped BPSK/QPSK/QAM.
// Mixes with an external LO, integrates each symbol, slices to hard bits and
// re-serialises them as a data_out/data_clk pair.
module qam_rect_demod
   import qam_pkg::*;
#(
   parameter int SPS_LOG2 = 4,
   parameter int BIT_DIV  = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic signed [15:0] din,
   input  logic signed [15:0] lo_i,
   input  logic signed [15:0] lo_q,
   input  logic               sym_stb,
   input  logic        [1:0]  syb,
   output logic signed [15:0] sym_i,
   output logic signed [15:0] sym_q,
   output logic        [5:0]  sym_bits,
   output logic               sym_valid,
   output logic               len_err,
   output logic               sat,
   output logic               overrun,
   output logic               data_out,
   output logic               data_clk
);

   localparam int ACC_W = SAMPLE_W + SPS_LOG2 + 1;
   localparam int CNT_W = SPS_LOG2 + 2;
   localparam int DIV_W = $clog2(BIT_DIV);
   localparam logic [CNT_W-1:0] SYM_LEN  = CNT_W'(2 ** SPS_LOG2);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_MID  = DIV_W'(BIT_DIV / 2);

   // Stage 1 state
   logic signed [16:0]      mi, mq;
   logic                    stb_d;
   syb_e                    syb_d;

   // Stage 2 state
   logic signed [ACC_W-1:0] acc_i, acc_q, hold_i, hold_q;
   logic        [CNT_W-1:0] cnt;
   logic                    first_sym;
   logic                    dump;
   logic                    dump_len_err;
   syb_e                    syb_prev, dump_syb;

   // Stage 3 combinational path
   logic signed [ACC_W-1:0] scaled_i, scaled_q;
   logic signed [15:0]      lim_i, lim_q;
   logic                    sat_now;
   logic        [2:0]       n_axis, idx_i, idx_q;
   logic        [5:0]       bits_now;
   syb_e                    sym_syb;

   // Serialiser state
   ser_state_e              state;
   logic        [4:0]       shreg;
   logic        [2:0]       bits_left;
   logic        [DIV_W-1:0] div;
   logic        [2:0]       sym_n;
   logic        [5:0]       load_word;
   logic                    last_tick;

   // Mix with the LO; strobe and format follow the product pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments only.
         mi    <= '0;
         mq    <= '0;
         stb_d <= 1'b0;
         syb_d <= SYB_BPSK;
      end else begin
         mi    <= 17'((32'(din) * 32'(lo_i)) >>> 15);
         mq    <= 17'((32'(din) * 32'(lo_q)) >>> 15);
         stb_d <= sym_stb;
         syb_d <= syb_e'(syb);
      end
   end

   // Integrate-and-dump; syb_prev is the format of the symbol's last sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_i        <= '0;
         acc_q        <= '0;
         hold_i       <= '0;
         hold_q       <= '0;
         cnt          <= '0;
         first_sym    <= 1'b1;
         dump         <= 1'b0;
         dump_len_err <= 1'b0;
         syb_prev     <= SYB_BPSK;
         dump_syb     <= SYB_BPSK;
      end else begin
         dump     <= 1'b0;
         syb_prev <= syb_d;
         if (stb_d) begin
            acc_i     <= ACC_W'(mi);
            acc_q     <= ACC_W'(mq);
            cnt       <= CNT_W'(1);
            first_sym <= 1'b0;
            // The very first strobe closes a partial, meaningless symbol.
            if (!first_sym) begin
               hold_i       <= acc_i;
               hold_q       <= acc_q;
               dump         <= 1'b1;
               dump_len_err <= (cnt != SYM_LEN);
               dump_syb     <= syb_prev;
            end
         end else begin
            acc_i <= acc_i + ACC_W'(mi);
            acc_q <= acc_q + ACC_W'(mq);
            if (cnt != '1)
               cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // Divide by half the symbol length: the x2 restores the cos^2 mixing loss.
   assign scaled_i = hold_i >>> (SPS_LOG2 - 1);
   assign scaled_q = hold_q >>> (SPS_LOG2 - 1);
   assign lim_i    = sat16(32'(scaled_i));
   assign lim_q    = sat16(32'(scaled_q));
   assign sat_now  = (32'(scaled_i) != 32'(lim_i)) || (32'(scaled_q) != 32'(lim_q));
   assign n_axis   = bits_per_axis(dump_syb);

   qam_slicer u_slice_i (.v(lim_i), .n(n_axis), .idx(idx_i));
   qam_slicer u_slice_q (.v(lim_q), .n(n_axis), .idx(idx_q));

   // Pack the axis decisions right-aligned; BPSK carries I only.
   always_comb begin
      bits_now = '0;
      case (dump_syb)
         SYB_BPSK:  bits_now = {5'b0, idx_i[0]};
         SYB_QPSK:  bits_now = {4'b0, idx_i[0], idx_q[0]};
         SYB_16QAM: bits_now = {2'b0, idx_i[1:0], idx_q[1:0]};
         default:   bits_now = {idx_i, idx_q};
      endcase
   end

   // Register the symbol result; flags are single-cycle companions of sym_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sym_i     <= '0;
         sym_q     <= '0;
         sym_bits  <= '0;
         sym_valid <= 1'b0;
         len_err   <= 1'b0;
         sat       <= 1'b0;
         sym_syb   <= SYB_BPSK;
      end else begin
         sym_valid <= dump;
         len_err   <= dump & dump_len_err;
         sat       <= dump & sat_now;
         if (dump) begin
            sym_i    <= lim_i;
            sym_q    <= lim_q;
            sym_bits <= bits_now;
            sym_syb  <= dump_syb;
         end
      end
   end

   assign sym_n     = bits_per_sym(sym_syb);
   assign load_word = sym_bits << (3'd6 - sym_n);
   // On the final clock of the last bit the serialiser is effectively free.
   assign last_tick = (state == SER_SHIFT) && (bits_left == 3'd1) && (div == DIV_LAST);

   // Serialiser: MSB first, BIT_DIV clocks per bit, data_clk mid-bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= SER_IDLE;
         shreg     <= '0;
         bits_left <= '0;
         div       <= '0;
         data_out  <= 1'b0;
         data_clk  <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         data_clk <= 1'b0;
         if (sym_valid) begin
            if ((state == SER_SHIFT) && !last_tick)
               overrun <= 1'b1;
            state     <= SER_SHIFT;
            data_out  <= load_word[5];
            shreg     <= load_word[4:0];
            bits_left <= sym_n;
            div       <= '0;
         end else if (state == SER_SHIFT) begin
            if (div == DIV_LAST) begin
               div <= '0;
               if (bits_left == 3'd1) begin
                  state    <= SER_IDLE;
                  data_out <= 1'b0;
               end else begin
                  data_out  <= shreg[4];
                  shreg     <= {shreg[3:0], 1'b0};
                  bits_left <= bits_left - 3'd1;
               end
            end else begin
               div      <= div + DIV_W'(1);
               data_clk <= ((div + DIV_W'(1)) == DIV_MID);
            end
         end
      end
   end

endmodule

// File: tb/tb_qam_rect_demod.sv
// Self-checking bench for qam_rect_demod: table of constant-input symbols with
// hand-derived results, a scoreboard for symbol outputs, and serial/overrun/
// reset sequences on a default instance and a BIT_DIV=8 instance.
module tb_qam_rect_demod;

   typedef struct {
      int din;
      int lo_i;
      int lo_q;
      int syb;
      int len;
      int exp_i;
      int exp_q;
      int exp_bits;
      int exp_len;
      int exp_sat;
   } vec_t;

   logic               clk;
   logic               rst;
   logic signed [15:0] din, lo_i, lo_q;
   logic               sym_stb;
   logic        [1:0]  syb;

   logic signed [15:0] sym_i, sym_q, sym_i_8, sym_q_8;
   logic        [5:0]  sym_bits, sym_bits_8;
   logic               sym_valid, len_err, sat, overrun, data_out, data_clk;
   logic               sym_valid_8, len_err_8, sat_8, overrun_8, data_out_8, data_clk_8;

   int   errors = 0;
   int   checks = 0;
   int   n_valid = 0;
   vec_t vecs[11];
   vec_t sb_q[$];
   vec_t mon_v;
   bit   ser_q[$];
   bit   ser8_q[$];
   bit   exp_ser[9]  = '{1, 1, 0, 0, 1, 1, 1, 1, 0};
   bit   exp_ser8[7] = '{1, 1, 0, 1, 1, 1, 0};

   qam_rect_demod #(.SPS_LOG2(4), .BIT_DIV(4)) u_dut (
      .clk(clk), .rst(rst), .din(din), .lo_i(lo_i), .lo_q(lo_q),
      .sym_stb(sym_stb), .syb(syb),
      .sym_i(sym_i), .sym_q(sym_q), .sym_bits(sym_bits), .sym_valid(sym_valid),
      .len_err(len_err), .sat(sat), .overrun(overrun),
      .data_out(data_out), .data_clk(data_clk)
   );

   qam_rect_demod #(.SPS_LOG2(4), .BIT_DIV(8)) u_dut8 (
      .clk(clk), .rst(rst), .din(din), .lo_i(lo_i), .lo_q(lo_q),
      .sym_stb(sym_stb), .syb(syb),
      .sym_i(sym_i_8), .sym_q(sym_q_8), .sym_bits(sym_bits_8), .sym_valid(sym_valid_8),
      .len_err(len_err_8), .sat(sat_8), .overrun(overrun_8),
      .data_out(data_out_8), .data_clk(data_clk_8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int d, input int li, input int lq, input int sy,
                               input int ln, input int ei, input int eq, input int eb,
                               input int el, input int es);
      vec_t v;
      v.din = d;  v.lo_i = li; v.lo_q = lq; v.syb = sy; v.len = ln;
      v.exp_i = ei; v.exp_q = eq; v.exp_bits = eb; v.exp_len = el; v.exp_sat = es;
      return v;
   endfunction

   task automatic drive_symbol(input vec_t v);
      for (int k = 0; k < v.len; k++) begin
         @(negedge clk);
         din     = 16'(v.din);
         lo_i    = 16'(v.lo_i);
         lo_q    = 16'(v.lo_q);
         syb     = 2'(v.syb);
         sym_stb = (k == 0);
         if (k == 0) sb_q.push_back(v);
      end
   endtask

   task automatic close_strobe();
      @(negedge clk);
      din = '0; lo_i = '0; lo_q = '0; syb = '0; sym_stb = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk) begin
         sym_stb = 1'b0;
         din     = '0;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_sym_i"},     sym_i,     0);
      check({tag, "_sym_q"},     sym_q,     0);
      check({tag, "_sym_bits"},  sym_bits,  0);
      check({tag, "_sym_valid"}, sym_valid, 0);
      check({tag, "_len_err"},   len_err,   0);
      check({tag, "_sat"},       sat,       0);
      check({tag, "_overrun"},   overrun,   0);
      check({tag, "_data_out"},  data_out,  0);
      check({tag, "_data_clk"},  data_clk,  0);
      check({tag, "_dut8_outs"},
            {sym_i_8, sym_q_8, sym_bits_8, sym_valid_8, len_err_8, sat_8,
             overrun_8, data_out_8, data_clk_8}, 0);
   endtask

   // Scoreboard monitor and serial capture, sampled away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (sym_valid) begin
            n_valid++;
            if (sb_q.size() == 0) begin
               check("unexpected_sym_valid", 1, 0);
            end else begin
               mon_v = sb_q.pop_front();
               check("sym_i",    sym_i,    mon_v.exp_i);
               check("sym_q",    sym_q,    mon_v.exp_q);
               check("sym_bits", sym_bits, mon_v.exp_bits);
               check("len_err",  len_err,  mon_v.exp_len);
               check("sat",      sat,      mon_v.exp_sat);
            end
         end else begin
            check("flags_without_valid", {len_err, sat}, 0);
         end
         if (data_clk)   ser_q.push_back(data_out);
         if (data_clk_8) ser8_q.push_back(data_out_8);
      end
   end

   initial begin
      //            din     lo_i    lo_q  syb len  exp_i   exp_q  bits len sat
      vecs[0]  = mk(  8192,  32767,      0, 0, 16,  16382,      0,  1, 0, 0);
      vecs[1]  = mk( 32767,  32767,      0, 2, 16,  32767,      0, 14, 0, 1);
      vecs[2]  = mk( -8192,  32767,  32767, 1, 16, -16384, -16384,  0, 0, 0);
      vecs[3]  = mk(  8192,  32767, -32768, 1, 16,  16382, -16384,  2, 0, 0);
      vecs[4]  = mk(  4096,  32767, -16384, 2, 16,   8190,  -4096,  9, 0, 0);
      vecs[5]  = mk( 16384, -32768,   8192, 3, 16, -32768,   8192,  6, 0, 0);
      vecs[6]  = mk(  8192,  32767,      0, 2, 12,  12286,      0, 14, 1, 0);
      vecs[7]  = mk( -8192,  32767,  32767, 2, 16, -16384, -16384,  0, 0, 0);
      vecs[8]  = mk( 32767,  32767,  32767, 1,  1,   4095,   4095,  3, 1, 0);
      vecs[9]  = mk(-32768, -32768,      0, 0, 16,  32767,      0,  1, 0, 1);
      vecs[10] = mk( 32767, -32768, -32768, 3, 16, -32768, -32768,  0, 0, 1);

      rst = 1'b1; sym_stb = 1'b0; din = '0; lo_i = '0; lo_q = '0; syb = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      #2 rst = 1'b0;

      // Table phase: first strobe is swallowed, each row emerges at the next strobe.
      idle(3);
      foreach (vecs[i]) drive_symbol(vecs[i]);
      close_strobe();
      idle(10);
      check("table_symbol_count", n_valid, 11);
      check("table_scoreboard_empty", sb_q.size(), 0);
      check("overrun_after_64qam", overrun, 1);

      // Asynchronous reset while serialising and accumulating.
      #2 rst = 1'b1;
      #1 check_all_zero("midrun_reset");
      @(negedge clk);
      ser_q.delete();
      ser8_q.delete();
      n_valid = 0;
      #2 rst = 1'b0;

      // Serial phase: BPSK then two 16QAM symbols at the nominal rate.
      idle(3);
      drive_symbol(vecs[0]);
      drive_symbol(vecs[4]);
      drive_symbol(vecs[1]);
      close_strobe();
      idle(60);
      check("serial_symbol_count", n_valid, 3);
      check("serial_scoreboard_empty", sb_q.size(), 0);
      check("no_overrun_bitdiv4", overrun, 0);
      check("overrun_bitdiv8", overrun_8, 1);
      check("serial_bit_count", ser_q.size(), 9);
      check("serial_bit_count_bitdiv8", ser8_q.size(), 7);
      for (int i = 0; i < 9; i++)
         if (i < ser_q.size()) check($sformatf("serial_bit%0d", i), ser_q[i], exp_ser[i]);
      for (int i = 0; i < 7; i++)
         if (i < ser8_q.size()) check($sformatf("serial8_bit%0d", i), ser8_q[i], exp_ser8[i]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
